stopwatch_seq: RTL and testbench
================================

// Module: stopwatch_seq
// PURPOSE
//  Run/stop/clear sequencer for the stopwatch BCD counter chain. Takes debounced button levels,
//  edge-detects them, runs a 4-state FSM and emits the counter controls: 10 ms count-enable tick,
//  one-cycle synchronous clear, and a display-hold flag for the 7-seg controller.
//  Sits between the chattering cutters and the stopwatch counter / sevenseg_ctrl.
// PARAMETERS
//  CLK_HZ   32000000  input clock frequency in Hz
//  TICK_HZ  100       count-enable tick rate in Hz; DIV = CLK_HZ/TICK_HZ, DIV >= 2 (integer)
//  PW       25        prescaler width in bits; 2**PW must be > DIV
// PORTS
//  clk         in   1   system clock, all logic on rising edge
//  rst         in   1   asynchronous, active-high reset
//  start_stop  in   1   debounced start/stop button level, 1 = pressed
//  clear       in   1   debounced clear (lap) button level, 1 = pressed
//  tick        out  1   one-cycle count-enable pulse to counter, rate TICK_HZ while counting
//  cnt_clr     out  1   one-cycle synchronous clear to counter and prescaler
//  disp_hold   out  1   1 = display shows frozen (lap) value
//  running     out  1   1 in RUN or LAP
//  state       out  2   FSM state: 00 IDLE, 01 RUN, 10 LAP, 11 STOP
// BEHAVIOUR
//  Reset: state=IDLE, tick=0, cnt_clr=0, disp_hold=0, running=0, prescaler=0,
//   button history regs=1 (a button held through reset release is NOT a press).
//  Press = rising edge of input vs. its 1-cycle-delayed copy (ss_p, clr_p); inputs already synchronous.
//  All outputs registered; state/running/disp_hold/cnt_clr update 1 clk after the edge-detect cycle.
//  Priority: ss_p beats clr_p; on simultaneous presses clr_p is dropped.
//  FSM:
//   IDLE: ss_p -> RUN.  clr_p -> IDLE, cnt_clr pulse (harmless re-clear).
//   RUN : ss_p -> STOP. clr_p -> LAP, disp_hold=1 (LAP_EN only; else ignored).
//   LAP : ss_p -> STOP, disp_hold=0. clr_p -> RUN, disp_hold=0. Counting continues in LAP.
//   STOP: ss_p -> RUN.  clr_p -> IDLE with one-cycle cnt_clr.
//  Prescaler: counts 0..DIV-1 only while running=1; tick=1 for the cycle after prescaler==DIV-1,
//   prescaler wraps to 0 there. Frozen (value kept) in STOP; so STOP->RUN resumes mid-period.
//   Set to 0 whenever cnt_clr is issued. tick is never asserted while running=0.
//  First tick after IDLE->RUN arrives exactly DIV clks after running rises.
//  Rst asserted mid-RUN/LAP: immediate return to reset values, no cnt_clr pulse issued
//   (counter is reset by its own reset).
//  cnt_clr and tick are mutually exclusive (cnt_clr only from IDLE/STOP).
// CONFIGURATION
//  STOPWATCH_LAP_EN defined: LAP state reachable as above; disp_hold driven.
//  Not defined: clr_p in RUN ignored, LAP unreachable, disp_hold tied 0, state never 10.
// TESTING (bench overrides CLK_HZ=1000, TICK_HZ=100 -> DIV=10)
//  Reset with start_stop held 1, release rst -> state=00, no transition until start_stop
//   falls and rises again.
//  IDLE, pulse start_stop -> running=1 two clks after the press, first tick 10 clks after
//   running rises, then every 10 clks; 35 clks running -> 3 ticks.
//  RUN, press start_stop at prescaler=6 -> STOP, no ticks; press again -> RUN,
//   next tick 4 clks after running rises.
//  STOP, press clear -> exactly one cnt_clr cycle, state=00, prescaler=0.
//  LAP_EN: RUN, press clear -> state=10, disp_hold=1, ticks continue; press clear -> state=01,
//   disp_hold=0. Without LAP_EN same stimulus -> state stays 01, disp_hold=0.
//  RUN, start_stop and clear rise same cycle -> STOP, no LAP, no cnt_clr; assert rst in RUN ->
//   all outputs 0 within same cycle.

Source files
------------

// File: rtl/stopwatch_seq.sv
// Stopwatch run/stop/clear sequencer: button edge detect, 4-state FSM, 10 ms tick prescaler.
// Optional lap state is enabled by defining STOPWATCH_LAP_EN.
module stopwatch_seq #(
  parameter int CLK_HZ  = 32000000,
  parameter int TICK_HZ = 100,
  parameter int PW      = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_stop,
  input  logic       clear,
  output logic       tick,
  output logic       cnt_clr,
  output logic       disp_hold,
  output logic       running,
  output logic [1:0] state
);

  localparam int DIV = CLK_HZ / TICK_HZ;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_LAP  = 2'b10;
  localparam logic [1:0] S_STOP = 2'b11;

  logic          r_ss_d;
  logic          r_clr_d;
  logic          r_ss_p;
  logic          r_clr_p;
  logic [1:0]    r_state;
  logic          r_running;
  logic          r_tick;
  logic          r_cnt_clr;
  logic [PW-1:0] r_presc;

  logic [1:0]    w_state_nxt;
  logic          w_clr_pulse;
  logic          w_running_nxt;
  logic          w_advance;
  logic          w_wrap;

  // History regs reset to 1 so a button held through reset release is not a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ss_d  <= 1'b1;
      r_clr_d <= 1'b1;
      r_ss_p  <= 1'b0;
      r_clr_p <= 1'b0;
    end else begin
      r_ss_d  <= start_stop;
      r_clr_d <= clear;
      r_ss_p  <= start_stop & ~r_ss_d;
      r_clr_p <= clear & ~r_clr_d;
    end
  end

  // Next-state logic; start/stop always wins over a simultaneous clear.
  always_comb begin
    w_state_nxt = r_state;
    w_clr_pulse = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_ss_p) begin
          w_state_nxt = S_RUN;
        end else if (r_clr_p) begin
          w_state_nxt = S_IDLE;
          w_clr_pulse = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (r_ss_p) begin
          w_state_nxt = S_STOP;
        end
`ifdef STOPWATCH_LAP_EN
        else if (r_clr_p) begin
          w_state_nxt = S_LAP;
        end
`endif
        else begin
          w_state_nxt = S_RUN;
        end
      end
      S_LAP: begin
        if (r_ss_p) begin
          w_state_nxt = S_STOP;
        end else if (r_clr_p) begin
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_LAP;
        end
      end
      S_STOP: begin
        if (r_ss_p) begin
          w_state_nxt = S_RUN;
        end else if (r_clr_p) begin
          w_state_nxt = S_IDLE;
          w_clr_pulse = 1'b1;
        end else begin
          w_state_nxt = S_STOP;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Prescaler only advances on edges where running holds across the edge, so a tick never
  // lands in the cycle running drops and a stop/resume keeps the partial period.
  assign w_running_nxt = (w_state_nxt == S_RUN) | (w_state_nxt == S_LAP);
  assign w_advance     = r_running & w_running_nxt;
  assign w_wrap        = w_advance & (r_presc == PW'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_running <= 1'b0;
      r_cnt_clr <= 1'b0;
      r_tick    <= 1'b0;
      r_presc   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_running <= w_running_nxt;
      r_cnt_clr <= w_clr_pulse;
      r_tick    <= w_wrap;
      if (w_clr_pulse || w_wrap) begin
        r_presc <= '0;
      end else if (w_advance) begin
        r_presc <= r_presc + PW'(1);
      end else begin
        r_presc <= r_presc;
      end
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic r_disp_hold;

  // Display is frozen exactly while the FSM sits in LAP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_disp_hold <= 1'b0;
    end else begin
      r_disp_hold <= (w_state_nxt == S_LAP);
    end
  end

  assign disp_hold = r_disp_hold;
`else
  assign disp_hold = 1'b0;
`endif

  assign tick    = r_tick;
  assign cnt_clr = r_cnt_clr;
  assign running = r_running;
  assign state   = r_state;

endmodule

// File: tb/tb_stopwatch_seq.sv
// Scoreboard bench for stopwatch_seq: a cycle-level reference model queues expected outputs,
// a monitor compares them against the DUT; directed scenarios are followed by random buttons.
module tb_stopwatch_seq;

  localparam int DIV = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_stop = 1'b1;
  logic       clear = 1'b0;
  logic       tick;
  logic       cnt_clr;
  logic       disp_hold;
  logic       running;
  logic [1:0] state;

  int n_cmp = 0;
  int n_err = 0;

  logic [5:0] exp_q[$];

  // model state
  int m_state = 0;
  int m_acc = 0;
  bit m_prev_ss = 1'b1, m_prev_clr = 1'b1, m_pend_ss = 1'b0, m_pend_clr = 1'b0;

  stopwatch_seq #(.CLK_HZ(1000), .TICK_HZ(100), .PW(25)) dut (
    .clk(clk), .rst(rst), .start_stop(start_stop), .clear(clear),
    .tick(tick), .cnt_clr(cnt_clr), .disp_hold(disp_hold), .running(running), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one expected output word per rising edge.
  always @(posedge clk) begin
    bit act_ss, act_clr, old_run, new_run, tk, cc;
    bit lap_en;
`ifdef STOPWATCH_LAP_EN
    lap_en = 1'b1;
`else
    lap_en = 1'b0;
`endif
    if (rst) begin
      m_state = 0; m_acc = 0;
      m_prev_ss = 1'b1; m_prev_clr = 1'b1; m_pend_ss = 1'b0; m_pend_clr = 1'b0;
      exp_q.push_back(6'b0);
    end else begin
      act_ss  = m_pend_ss;
      act_clr = m_pend_clr && !m_pend_ss;
      m_pend_ss  = start_stop && !m_prev_ss;
      m_pend_clr = clear && !m_prev_clr;
      m_prev_ss  = start_stop;
      m_prev_clr = clear;
      old_run = (m_state == 1) || (m_state == 2);
      cc = 1'b0;
      if (m_state == 0) begin
        if (act_ss) m_state = 1;
        else if (act_clr) cc = 1'b1;
      end else if (m_state == 1) begin
        if (act_ss) m_state = 3;
        else if (act_clr && lap_en) m_state = 2;
      end else if (m_state == 2) begin
        if (act_ss) m_state = 3;
        else if (act_clr) m_state = 1;
      end else begin
        if (act_ss) m_state = 1;
        else if (act_clr) begin m_state = 0; cc = 1'b1; end
      end
      new_run = (m_state == 1) || (m_state == 2);
      tk = 1'b0;
      if (old_run && new_run) begin
        m_acc++;
        if (m_acc == DIV) begin m_acc = 0; tk = 1'b1; end
      end
      if (cc) m_acc = 0;
      exp_q.push_back({tk, cc, (m_state == 2), new_run, 2'(m_state)});
    end
  end

  // Monitor: pops one expectation per edge and compares the registered outputs.
  always @(posedge clk) begin
    logic [5:0] e;
    #2;
    if (exp_q.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL scoreboard: no expectation queued at %0t", $time);
    end else begin
      e = exp_q.pop_front();
      chk("outputs{tick,clr,hold,run,state}", int'({tick, cnt_clr, disp_hold, running, state}), int'(e));
    end
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int n;
    int ticks;
    int clrs;
    // reset with start_stop held high
    wait_neg(3);
    chk("reset_state", int'(state), 0);
    rst = 1'b0;
    wait_neg(3);
    chk("held_button_no_press", int'(state), 0);
    start_stop = 1'b0;
    wait_neg(2);
    start_stop = 1'b1;
    wait_neg(1);
    chk("running_one_clk_after_press", int'(running), 0);
    wait_neg(1);
    chk("running_two_clks_after_press", int'(running), 1);
    ticks = 0;
    for (int i = 0; i < 35; i++) begin
      if (i == 0) start_stop = 1'b0;
      @(negedge clk);
      ticks += int'(tick);
    end
    chk("ticks_in_35_clks", ticks, 3);
    // stop with prescaler at 6
    start_stop = 1'b1;
    wait_neg(2);
    chk("stopped_state", int'(state), 3);
    start_stop = 1'b0;
    ticks = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      ticks += int'(tick);
    end
    chk("no_ticks_in_stop", ticks, 0);
    start_stop = 1'b1;
    n = 0;
    while (!running && n < 10) begin @(negedge clk); n++; end
    chk("resume_running", int'(running), 1);
    start_stop = 1'b0;
    n = 0;
    while (!tick && n < 20) begin @(negedge clk); n++; end
    chk("resume_tick_delay", n, 4);
    // stop, then clear
    start_stop = 1'b1;
    wait_neg(3);
    start_stop = 1'b0;
    chk("stop_before_clear", int'(state), 3);
    clear = 1'b1;
    clrs = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      clrs += int'(cnt_clr);
    end
    chk("single_cnt_clr", clrs, 1);
    chk("clear_to_idle", int'(state), 0);
    clear = 1'b0;
    // lap behaviour
    wait_neg(1);
    start_stop = 1'b1;
    wait_neg(3);
    start_stop = 1'b0;
    clear = 1'b1;
    wait_neg(3);
`ifdef STOPWATCH_LAP_EN
    chk("lap_state", int'(state), 2);
    chk("lap_hold", int'(disp_hold), 1);
`else
    chk("lap_ignored_state", int'(state), 1);
    chk("lap_ignored_hold", int'(disp_hold), 0);
`endif
    clear = 1'b0;
    wait_neg(2);
    clear = 1'b1;
    wait_neg(3);
    chk("lap_exit_state", int'(state), 1);
    chk("lap_exit_hold", int'(disp_hold), 0);
    clear = 1'b0;
    wait_neg(15);
    // simultaneous presses in RUN
    start_stop = 1'b1;
    clear = 1'b1;
    wait_neg(3);
    chk("simul_press_stop", int'(state), 3);
    start_stop = 1'b0;
    clear = 1'b0;
    wait_neg(2);
    start_stop = 1'b1;
    wait_neg(3);
    start_stop = 1'b0;
    wait_neg(4);
    // async reset mid-run
    rst = 1'b1;
    #1;
    chk("async_reset_outputs", int'({tick, cnt_clr, disp_hold, running, state}), 0);
    wait_neg(2);
    rst = 1'b0;
    // random phase
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 5) == 0) start_stop = ~start_stop;
      if ($urandom_range(0, 6) == 0) clear = ~clear;
      rst = ($urandom_range(0, 399) == 0);
    end
    rst = 1'b0;
    wait_neg(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
